serial_input_deser: RTL and testbench
=====================================

Name: serial_input_deser

Overview:
- Serial-to-parallel receiver for GF operand/result transport; the receive end of the team's LSB-first bit-serial output link.
- Collects DATA_WIDTH bits, one per clock, starting at a frame-start strobe, and presents the assembled word on a valid/ready output buffer.
- Sits between the chip-level serial pin and the GF arithmetic cores' parallel operand inputs.

Parameters:
- DATA_WIDTH, 32, bits per frame and output word width (>=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- in_serial  in  1  serial data bit, sampled every clock while receiving.
- in_start  in  1  frame-start strobe; high in the same cycle as bit 0.
- out_parallel  out  DATA_WIDTH  assembled word; stable while out_valid=1.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- overrun  out  1  sticky error: a completed word was dropped.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, bit counter=0, shift register=0, out_parallel=0, out_valid=0, overrun=0. Reset mid-frame discards the partial word and any held word.
- State IDLE: in_serial ignored unless in_start=1. On in_start=1: shift_reg[0]<=in_serial, counter<=1, go SHIFT.
- State SHIFT: each clock shift_reg[counter]<=in_serial, counter<=counter+1. The last bit is index DATA_WIDTH-1. At that edge, the completed word (including the bit just sampled) goes to the output buffer and state returns to IDLE.
- in_start=1 during SHIFT: the partial frame is abandoned and realigned. The current bit becomes bit 0, counter<=1, state stays SHIFT. No error is flagged.
- Frame period: back-to-back frames may have in_start in the cycle right after the last bit (zero gap). The serializer's one-cycle inter-frame gap is also tolerated.
- Latency: out_valid rises in the cycle after the edge that samples bit DATA_WIDTH-1.
- Output buffer: single entry. out_valid falls after the edge where out_valid && out_ready, unless a new word loads at that same edge.
- Word completes while the buffer is empty, or is being consumed at that edge: load out_parallel, out_valid=1, overrun unchanged.
- Word completes while out_valid=1 and out_ready=0: the new word is dropped, the held word is kept, overrun<=1.
- overrun stays set until reset.
- Counter width: $clog2(DATA_WIDTH)+1. The counter never exceeds DATA_WIDTH-1 while in SHIFT.

Optional Feature:
- Macro DESER_MSB_FIRST_EN.
- Defined: the first received bit is placed at index DATA_WIDTH-1 and later bits at descending indices, to interoperate with MSB-first transmitters.
- Undefined (default): LSB-first, where the first bit goes to index 0.
- Timing, handshake and overrun behaviour are identical in both builds.

Decomposition:
- Shared package gf_serial_pkg holds:
  - state enum {IDLE, SHIFT};
  - function for counter width from DATA_WIDTH;
  - default DATA_WIDTH constant shared with the transmitter.
- One sub-module is natural: deser_out_buf. It is the single-entry valid/ready holding register with drop-on-full and the sticky overrun flag.
- The shift/counter FSM stays in the top module.

Test Plan (DATA_WIDTH=8, default build unless noted):
1. Reset, then in_start with bits 1,0,1,0,0,1,0,1 on consecutive clocks, out_ready=1 -> out_parallel=0xA5, out_valid high exactly one cycle, starting the cycle after bit 7; overrun=0.
2. Same stimulus with DESER_MSB_FIRST_EN defined -> out_parallel=0xA5 bit-reversed = 0xA5 only if palindromic; use bits 1,1,0,0,0,0,0,0 -> 0xC0 (default build gives 0x03).
3. out_ready=0, send 0x3C then 0xFF back-to-back -> out_parallel stays 0x3C, out_valid=1, overrun=1 after frame 2. Raise out_ready -> 0x3C consumed, out_valid=0, overrun still 1.
4. Held word 0x11 with out_ready=1 asserted in the exact cycle frame 0x22 completes -> 0x11 accepted, out_parallel=0x22, out_valid stays 1, overrun=0.
5. in_start, 4 bits, then in_start again followed by 0x5A -> only 0x5A is delivered; no word from the abandoned frame.
6. resetn=0 at bit 5 of a frame, then a full frame 0x81 -> out_valid=0 during reset, only 0x81 is delivered, overrun=0.

Source files
------------

// File: rtl/gf_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gf_serial_pkg
//  Description : Shared definitions for the GF bit-serial operand link.
//                Holds the receiver state encoding, the bit-counter width
//                helper and the default frame width used by both the
//                serializer and the deserializer.
//  Contents    : GF_SERIAL_DATA_WIDTH  - default frame / word width
//                deser_state_e         - receiver state encoding
//                deser_cnt_width()     - bit-counter width for a frame width
//  Revision    : 1.0 - initial release
// ============================================================================
package gf_serial_pkg;

    // Default frame width shared with the transmit side of the link.
    localparam int unsigned GF_SERIAL_DATA_WIDTH = 32;

    // Receiver states: waiting for a frame-start strobe, or collecting bits.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_e;

    // Counter is one bit wider than the bit index so that a frame width
    // which is an exact power of two still has headroom.
    function automatic int unsigned deser_cnt_width(input int unsigned data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage : gf_serial_pkg
`default_nettype wire

// File: rtl/deser_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : deser_out_buf
//  Description : Single-entry valid/ready holding register for the serial
//                receiver. A completed word loads when the entry is empty or
//                is being consumed on the same edge; otherwise the incoming
//                word is dropped, the held word is kept, and a sticky
//                overrun flag is raised until reset.
//  Ports       : clk          - clock, posedge
//                resetn       - synchronous, active-low reset
//                i_load_valid - a completed word is offered this cycle
//                i_load_data  - the completed word
//                i_ready      - consumer accepts the held word
//                o_data       - held word, stable while o_valid=1
//                o_valid      - held word present
//                o_overrun    - sticky: a completed word was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module deser_out_buf
    import gf_serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GF_SERIAL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_load_valid,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    // The entry can take a new word if it is empty now, or if the word it
    // holds leaves on this very edge.
    logic w_can_load;
    assign w_can_load = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_load_valid) begin
                if (w_can_load) begin
                    r_data  <= i_load_data;
                    r_valid <= 1'b1;
                end else begin
                    // Held word wins; the newcomer is lost and flagged.
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule : deser_out_buf
`default_nettype wire

// File: rtl/serial_input_deser.sv
`default_nettype none
// ============================================================================
//  Module      : serial_input_deser
//  Description : Serial-to-parallel receiver for GF operand/result transport.
//                Collects DATA_WIDTH bits, one per clock, beginning with the
//                bit that arrives alongside in_start, and hands the finished
//                word to a single-entry valid/ready output buffer.
//                A new in_start while a frame is in progress abandons the
//                partial frame and restarts alignment on the current bit.
//  Build option: DESER_MSB_FIRST_EN - when defined, the first received bit
//                lands at index DATA_WIDTH-1 and later bits at descending
//                indices (MSB-first). Default is LSB-first.
//  Ports       : clk          - clock, posedge
//                resetn       - synchronous, active-low reset
//                in_serial    - serial data bit
//                in_start     - frame-start strobe, coincident with bit 0
//                out_parallel - assembled word, stable while out_valid=1
//                out_valid    - word available
//                out_ready    - consumer accepts on out_valid && out_ready
//                overrun      - sticky: a completed word was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_input_deser
    import gf_serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GF_SERIAL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_serial,
    input  logic                  in_start,
    output logic [DATA_WIDTH-1:0] out_parallel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int unsigned     CNT_W      = deser_cnt_width(DATA_WIDTH);
    localparam int unsigned     IDX_W      = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE_CNT  = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_TOP_IDX  = IDX_W'(DATA_WIDTH - 1);

    deser_state_e          r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;

    logic [IDX_W-1:0]      w_pos;
    logic [IDX_W-1:0]      w_bit_idx;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_sampling;
    logic                  w_word_done;

    // Position of the current bit within its frame. A start strobe always
    // makes the current bit position 0, whether or not a frame was running.
    // The counter never exceeds DATA_WIDTH-1, so its low bits are the index.
    assign w_pos = in_start ? '0 : r_cnt[IDX_W-1:0];

`ifdef DESER_MSB_FIRST_EN
    assign w_bit_idx = c_TOP_IDX - w_pos;
`else
    assign w_bit_idx = w_pos;
    // The top index is only needed for MSB-first placement.
    logic w_unused_top;
    assign w_unused_top = ^c_TOP_IDX;
`endif

    // Bit is captured whenever a frame is in progress or is starting now.
    assign w_sampling = in_start || (r_state == SHIFT);

    // The final bit of a frame: still shifting, no restart, counter at the
    // last index. The buffer is fed the word including this bit.
    assign w_word_done = (r_state == SHIFT) && !in_start && (r_cnt == c_LAST_CNT);

    always_comb begin
        w_shift_next            = r_shift;
        w_shift_next[w_bit_idx] = in_serial;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            if (w_sampling) begin
                r_shift <= w_shift_next;
            end

            case (r_state)
                IDLE: begin
                    if (in_start) begin
                        r_cnt   <= c_ONE_CNT;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (in_start) begin
                        // Realign on the current bit; nothing is flagged.
                        r_cnt <= c_ONE_CNT;
                    end else if (w_word_done) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_ONE_CNT;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    deser_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk          (clk),
        .resetn       (resetn),
        .i_load_valid (w_word_done),
        .i_load_data  (w_shift_next),
        .i_ready      (out_ready),
        .o_data       (out_parallel),
        .o_valid      (out_valid),
        .o_overrun    (overrun)
    );

endmodule : serial_input_deser
`default_nettype wire

// File: tb/tb_serial_input_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_input_deser
//  Description : Self-checking bench for serial_input_deser at DATA_WIDTH=8.
//                A frame-level reference model (bit queue + one-entry buffer)
//                predicts outputs; directed scenarios also check constants.
//                Honours DESER_MSB_FIRST_EN for expected bit placement.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_input_deser;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_serial = 1'b0;
    logic          in_start = 1'b0;
    logic [DW-1:0] out_parallel;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_deliv  = 0;

    // Reference model state
    bit            m_q[$];
    bit            m_collect = 1'b0;
    logic [DW-1:0] m_data = '0;
    bit            m_valid = 1'b0;
    bit            m_ovr = 1'b0;

    serial_input_deser #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_serial    (in_serial),
        .in_start     (in_start),
        .out_parallel (out_parallel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Counts words actually handed to the consumer.
    always @(posedge clk) begin
        if (resetn && out_valid && out_ready) n_deliv <= n_deliv + 1;
    end

    function automatic logic [DW-1:0] assemble();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++) begin
`ifdef DESER_MSB_FIRST_EN
            w[DW-1-i] = m_q[i];
`else
            w[i] = m_q[i];
`endif
        end
        return w;
    endfunction

    // Advance the model with the inputs currently applied, then cross one edge.
    task automatic tick();
        logic [DW-1:0] word;
        bit done;
        word = '0;
        done = 1'b0;
        if (!resetn) begin
            m_q.delete();
            m_collect = 1'b0;
            m_valid   = 1'b0;
            m_data    = '0;
            m_ovr     = 1'b0;
        end else begin
            if (in_start) begin
                m_q.delete();
                m_q.push_back(in_serial);
                m_collect = 1'b1;
            end else if (m_collect) begin
                m_q.push_back(in_serial);
            end
            if (m_collect && m_q.size() == DW) begin
                word = assemble();
                done = 1'b1;
                m_q.delete();
                m_collect = 1'b0;
            end
            if (done) begin
                if (!m_valid || out_ready) begin
                    m_data  = word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        resetn   = 1'b0;
        in_start = 1'b0;
        repeat (n) tick();
        resetn = 1'b1;
    endtask

    // Sends w so that it is reassembled as w in the current build.
    task automatic send_word(input logic [DW-1:0] w, input logic rdy_body, input logic rdy_last);
        for (int i = 0; i < DW; i++) begin
            in_start = (i == 0);
`ifdef DESER_MSB_FIRST_EN
            in_serial = w[DW-1-i];
`else
            in_serial = w[i];
`endif
            out_ready = (i == DW-1) ? rdy_last : rdy_body;
            tick();
        end
        in_start = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset(3);
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_parallel !== '0) begin n_errors++; $display("FAIL reset_data: got %h want 00", out_parallel); end
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] tx;
        tx = 8'hA5;
        do_reset(1);
        out_ready = 1'b1;
        for (int i = 0; i < DW; i++) begin
            in_start  = (i == 0);
            in_serial = tx[i];
            tick();
            if (i < DW-1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid bit%0d: got %b want 0", i, out_valid); end
            end
        end
        in_start = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_checks++;
        if (out_parallel !== 8'hA5) begin n_errors++; $display("FAIL basic_data: got %h want a5", out_parallel); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_one_cycle: got %b want 0", out_valid); end
        n_checks++;
        if (overrun !== 1'b0) begin n_errors++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_bit_order();
        logic [DW-1:0] tx;
        logic [DW-1:0] exp;
        tx = 8'h03;
`ifdef DESER_MSB_FIRST_EN
        exp = 8'hC0;
`else
        exp = 8'h03;
`endif
        do_reset(1);
        out_ready = 1'b1;
        for (int i = 0; i < DW; i++) begin
            in_start  = (i == 0);
            in_serial = tx[i];
            tick();
        end
        in_start = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_parallel !== exp) begin
            n_errors++; $display("FAIL bit_order: got v=%b d=%h want v=1 d=%h", out_valid, out_parallel, exp);
        end
    endtask

    task automatic test_overrun();
        do_reset(1);
        send_word(8'h3C, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_parallel !== 8'h3C || overrun !== 1'b0) begin
            n_errors++; $display("FAIL ovr_first: got v=%b d=%h o=%b want 1 3c 0", out_valid, out_parallel, overrun);
        end
        send_word(8'hFF, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_parallel !== 8'h3C) begin
            n_errors++; $display("FAIL ovr_held: got v=%b d=%h want 1 3c", out_valid, out_parallel);
        end
        n_checks++;
        if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
        tick();
        n_checks++;
        if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_accept_same_cycle();
        int d0;
        do_reset(1);
        send_word(8'h11, 1'b0, 1'b0);
        out_ready = 1'b0;
        tick();
        d0 = n_deliv;
        send_word(8'h22, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_parallel !== 8'h22 || overrun !== 1'b0) begin
            n_errors++; $display("FAIL same_cycle: got v=%b d=%h o=%b want 1 22 0", out_valid, out_parallel, overrun);
        end
        n_checks++;
        if (n_deliv - d0 !== 1) begin n_errors++; $display("FAIL same_cycle_accept: got %0d want 1", n_deliv - d0); end
    endtask

    task automatic test_realign();
        int d0;
        logic [DW-1:0] w;
        do_reset(1);
        out_ready = 1'b1;
        d0 = n_deliv;
        for (int i = 0; i < 4; i++) begin
            in_start  = (i == 0);
            in_serial = 1'($urandom);
            tick();
        end
        w = 8'h5A;
        for (int i = 0; i < DW; i++) begin
            in_start = (i == 0);
`ifdef DESER_MSB_FIRST_EN
            in_serial = w[DW-1-i];
`else
            in_serial = w[i];
`endif
            tick();
            if (i < DW-1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_errors++; $display("FAIL realign_stray bit%0d: got %b want 0", i, out_valid); end
            end
        end
        in_start = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_parallel !== 8'h5A) begin
            n_errors++; $display("FAIL realign_word: got v=%b d=%h want 1 5a", out_valid, out_parallel);
        end
        tick();
        n_checks++;
        if (n_deliv - d0 !== 1 || overrun !== 1'b0) begin
            n_errors++; $display("FAIL realign_count: got n=%0d o=%b want 1 0", n_deliv - d0, overrun);
        end
    endtask

    task automatic test_reset_midframe();
        int d0;
        do_reset(1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_start  = (i == 0);
            in_serial = 1'($urandom);
            tick();
        end
        in_start = 1'b0;
        resetn   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
        end
        resetn = 1'b1;
        d0 = n_deliv;
        for (int i = 0; i < 3; i++) begin
            in_serial = 1'($urandom);
            tick();
        end
        send_word(8'h81, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_parallel !== 8'h81 || overrun !== 1'b0) begin
            n_errors++; $display("FAIL midreset_word: got v=%b d=%h o=%b want 1 81 0", out_valid, out_parallel, overrun);
        end
        tick();
        n_checks++;
        if (n_deliv - d0 !== 1) begin n_errors++; $display("FAIL midreset_count: got %0d want 1", n_deliv - d0); end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int c = 0; c < 1500; c++) begin
            resetn    = ($urandom_range(0, 149) != 0);
            in_start  = ($urandom_range(0, 7) == 0);
            in_serial = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (out_valid !== m_valid) begin n_errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, m_valid); end
            n_checks++;
            if (overrun !== m_ovr) begin n_errors++; $display("FAIL rand_overrun c%0d: got %b want %b", c, overrun, m_ovr); end
            if (m_valid) begin
                n_checks++;
                if (out_parallel !== m_data) begin n_errors++; $display("FAIL rand_data c%0d: got %h want %h", c, out_parallel, m_data); end
            end
        end
        resetn   = 1'b1;
        in_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_order();
        test_overrun();
        test_accept_same_cycle();
        test_realign();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_serial_input_deser
`default_nettype wire
